// File: rtl/ysyx_22041071_mem_stage.sv
// ysyx_22041071_mem_stage
// Memory-access stage between EX and WB. Takes EX results over valid/ready,
// issues loads/stores through a req/ack data-memory port, aligns store data and
// byte masks, formats load data by funct3 and byte offset, and holds finished
// results until WB takes them.
//
// Optional feature: define YSYX_22041071_MEM_ALIGN_CHK_EN to flag misaligned
// accesses and retire them without touching memory. Without it, misalign is
// always 0 and every access is issued exactly as computed.

module ysyx_22041071_mem_stage (
    input  logic        clk,
    input  logic        reset,

    // EX side
    input  logic        valid5,
    output logic        ready5,
    input  logic [63:0] PC5,
    input  logic [31:0] Ins4,
    input  logic        MEM_W_en3,
    input  logic        WB_sel3,
    input  logic        reg_w_en3,
    input  logic [63:0] rt_data2,
    input  logic [4:0]  rdest2,
    input  logic [63:0] ALU_result1,

    // data memory port
    output logic        mem_req,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,

    // WB side
    output logic        valid6,
    input  logic        ready6,
    output logic [63:0] PC6,
    output logic [31:0] Ins5,
    output logic        WB_sel4,
    output logic        reg_w_en4,
    output logic [4:0]  rdest3,
    output logic [63:0] ALU_result2,
    output logic [63:0] MEM_data1,
    output logic        misalign
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Shift the doubleword down to the addressed byte, then size/extend.
    function automatic logic [63:0] fmt_load(input logic [2:0]  f3,
                                             input logic [2:0]  off,
                                             input logic [63:0] rdata);
        logic [63:0] raw;
        raw = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  return {{56{raw[7]}},  raw[7:0]};
            3'b001:  return {{48{raw[15]}}, raw[15:0]};
            3'b010:  return {{32{raw[31]}}, raw[31:0]};
            3'b011:  return raw;
            3'b100:  return {56'd0, raw[7:0]};
            3'b101:  return {48'd0, raw[15:0]};
            3'b110:  return {32'd0, raw[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    // Byte mask for the store size, moved to the addressed lane. Bits pushed
    // past lane 7 fall off the 8-bit result.
    function automatic logic [7:0] st_mask(input logic [1:0] size,
                                           input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

`ifdef YSYX_22041071_MEM_ALIGN_CHK_EN
    // Natural-alignment check; funct3 111 on a load is not an access size.
    function automatic logic chk_misalign(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [2:0] off);
        if (!is_store && f3 == 3'b111)
            return 1'b0;
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction
`endif

    // ------------------------------------------------------------------
    // Incoming request decode
    // ------------------------------------------------------------------
    logic [2:0]  in_f3;
    logic [2:0]  in_off;
    logic        in_is_mem;
    logic        in_is_load;
    logic        in_misalign;
    logic        accept;
    logic        issue_mem;
    logic        load_direct;
    logic        load_mem;
    logic [63:0] in_wdata;
    logic [7:0]  in_wmask;

    assign in_f3      = Ins4[14:12];
    assign in_off     = ALU_result1[2:0];
    // A store wins when both MEM_W_en3 and WB_sel3 are set.
    assign in_is_mem  = MEM_W_en3 | WB_sel3;
    assign in_is_load = WB_sel3 & ~MEM_W_en3;

`ifdef YSYX_22041071_MEM_ALIGN_CHK_EN
    assign in_misalign = in_is_mem & chk_misalign(MEM_W_en3, in_f3, in_off);
`else
    assign in_misalign = 1'b0;
`endif

    assign ready5      = (state == IDLE) && (!valid6 || ready6);
    assign accept      = valid5 && ready5;
    assign issue_mem   = accept && in_is_mem && !in_misalign;
    assign load_direct = accept && (!in_is_mem || in_misalign);
    assign load_mem    = (state == BUSY) && mem_ack;

    assign in_wdata = MEM_W_en3 ? (rt_data2 << {in_off, 3'b000}) : 64'd0;
    assign in_wmask = MEM_W_en3 ? st_mask(in_f3[1:0], in_off) : 8'd0;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state: enter BUSY on an issued access, leave on mem_ack.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (issue_mem) state_next = BUSY;
            BUSY:    if (mem_ack)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request is purely a function of state, so reset drops it immediately.
    assign mem_req = (state == BUSY);

    // ------------------------------------------------------------------
    // In-flight request fields
    // ------------------------------------------------------------------
    logic [63:0] req_pc;
    logic [31:0] req_ins;
    logic        req_wb_sel;
    logic        req_reg_w_en;
    logic        req_is_load;
    logic [4:0]  req_rdest;
    logic [63:0] req_alu;

    // Capture the memory-port drive and the instruction fields at issue; they
    // stay frozen for the whole BUSY period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wen      <= 1'b0;
            mem_addr     <= 64'd0;
            mem_wdata    <= 64'd0;
            mem_wmask    <= 8'd0;
            req_pc       <= 64'd0;
            req_ins      <= 32'd0;
            req_wb_sel   <= 1'b0;
            req_reg_w_en <= 1'b0;
            req_is_load  <= 1'b0;
            req_rdest    <= 5'd0;
            req_alu      <= 64'd0;
        end else if (issue_mem) begin
            mem_wen      <= MEM_W_en3;
            mem_addr     <= {ALU_result1[63:3], 3'b000};
            mem_wdata    <= in_wdata;
            mem_wmask    <= in_wmask;
            req_pc       <= PC5;
            req_ins      <= Ins4;
            req_wb_sel   <= WB_sel3;
            req_reg_w_en <= reg_w_en3;
            req_is_load  <= in_is_load;
            req_rdest    <= rdest2;
            req_alu      <= ALU_result1;
        end
    end

    // ------------------------------------------------------------------
    // Result registers toward WB
    // ------------------------------------------------------------------

    // Load results from EX directly (non-memory or rejected access) or from
    // the in-flight fields on mem_ack; otherwise hold until WB takes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid6      <= 1'b0;
            PC6         <= 64'd0;
            Ins5        <= 32'd0;
            WB_sel4     <= 1'b0;
            reg_w_en4   <= 1'b0;
            rdest3      <= 5'd0;
            ALU_result2 <= 64'd0;
            MEM_data1   <= 64'd0;
            misalign    <= 1'b0;
        end else if (load_direct) begin
            valid6      <= 1'b1;
            PC6         <= PC5;
            Ins5        <= Ins4;
            WB_sel4     <= WB_sel3;
            reg_w_en4   <= reg_w_en3 & ~in_misalign;
            rdest3      <= rdest2;
            ALU_result2 <= ALU_result1;
            MEM_data1   <= 64'd0;
            misalign    <= in_misalign;
        end else if (load_mem) begin
            valid6      <= 1'b1;
            PC6         <= req_pc;
            Ins5        <= req_ins;
            WB_sel4     <= req_wb_sel;
            reg_w_en4   <= req_reg_w_en;
            rdest3      <= req_rdest;
            ALU_result2 <= req_alu;
            MEM_data1   <= req_is_load
                           ? fmt_load(req_ins[14:12], req_alu[2:0], mem_rdata)
                           : 64'd0;
            misalign    <= 1'b0;
        end else if (valid6 && ready6) begin
            valid6      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_mem_stage.sv
// Directed self-checking bench for ysyx_22041071_mem_stage.

module tb_ysyx_22041071_mem_stage;

    logic        clk;
    logic        reset;
    logic        valid5;
    logic        ready5;
    logic [63:0] PC5;
    logic [31:0] Ins4;
    logic        MEM_W_en3;
    logic        WB_sel3;
    logic        reg_w_en3;
    logic [63:0] rt_data2;
    logic [4:0]  rdest2;
    logic [63:0] ALU_result1;
    logic        mem_req;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        valid6;
    logic        ready6;
    logic [63:0] PC6;
    logic [31:0] Ins5;
    logic        WB_sel4;
    logic        reg_w_en4;
    logic [4:0]  rdest3;
    logic [63:0] ALU_result2;
    logic [63:0] MEM_data1;
    logic        misalign;

    int n_cmp;
    int n_fail;

    ysyx_22041071_mem_stage dut (
        .clk         (clk),
        .reset       (reset),
        .valid5      (valid5),
        .ready5      (ready5),
        .PC5         (PC5),
        .Ins4        (Ins4),
        .MEM_W_en3   (MEM_W_en3),
        .WB_sel3     (WB_sel3),
        .reg_w_en3   (reg_w_en3),
        .rt_data2    (rt_data2),
        .rdest2      (rdest2),
        .ALU_result1 (ALU_result1),
        .mem_req     (mem_req),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .valid6      (valid6),
        .ready6      (ready6),
        .PC6         (PC6),
        .Ins5        (Ins5),
        .WB_sel4     (WB_sel4),
        .reg_w_en4   (reg_w_en4),
        .rdest3      (rdest3),
        .ALU_result2 (ALU_result2),
        .MEM_data1   (MEM_data1),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One cycle, then settle past the edge before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ins(input logic [2:0] f3,
                                           input logic [6:0] opcode);
        return {17'd0, f3, 5'd10, opcode};
    endfunction

    task automatic drive_op(input logic [63:0] pc, input logic [31:0] ins,
                            input logic wen, input logic wbsel, input logic rwen,
                            input logic [63:0] rt, input logic [4:0] rd,
                            input logic [63:0] alu);
        valid5      = 1'b1;
        PC5         = pc;
        Ins4        = ins;
        MEM_W_en3   = wen;
        WB_sel3     = wbsel;
        reg_w_en3   = rwen;
        rt_data2    = rt;
        rdest2      = rd;
        ALU_result1 = alu;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        valid5 = 1'b0; PC5 = '0; Ins4 = '0; MEM_W_en3 = 1'b0; WB_sel3 = 1'b0;
        reg_w_en3 = 1'b0; rt_data2 = '0; rdest2 = '0; ALU_result1 = '0;
        mem_ack = 1'b0; mem_rdata = '0; ready6 = 1'b1;

        // ---------------- reset state ----------------
        #12;
        check("rst_mem_req",   mem_req,     0);
        check("rst_mem_wen",   mem_wen,     0);
        check("rst_valid6",    valid6,      0);
        check("rst_misalign",  misalign,    0);
        check("rst_mem_addr",  mem_addr,    0);
        check("rst_mem_wmask", mem_wmask,   0);
        check("rst_mem_wdata", mem_wdata,   0);
        check("rst_PC6",       PC6,         0);
        check("rst_MEM_data1", MEM_data1,   0);
        check("rst_reg_w_en4", reg_w_en4,   0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready5", ready5, 1);
        tick();

        // ---------------- ALU pass-through ----------------
        drive_op(64'h8000_0000, mk_ins(3'b000, 7'h33), 0, 0, 1, 64'd0, 5'd5, 64'h1234);
        #1;
        check("pt_ready5_pre", ready5, 1);
        tick();
        valid5 = 1'b0;
        check("pt_valid6",      valid6,      1);
        check("pt_ALU_result2", ALU_result2, 64'h1234);
        check("pt_rdest3",      rdest3,      5);
        check("pt_MEM_data1",   MEM_data1,   0);
        check("pt_PC6",         PC6,         64'h8000_0000);
        check("pt_reg_w_en4",   reg_w_en4,   1);
        check("pt_mem_req",     mem_req,     0);
        check("pt_ready5",      ready5,      1);
        tick();
        check("pt_valid6_drop", valid6, 0);

        // ---------------- stray ack in IDLE ----------------
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_valid6",  valid6,  0);
        check("idle_ack_mem_req", mem_req, 0);

        // ---------------- lb, ack after 3 BUSY cycles ----------------
        mem_rdata = 64'h0000_0000_8000_0000;
        drive_op(64'h8000_0010, mk_ins(3'b000, 7'h03), 0, 1, 1, 64'd0, 5'd10, 64'h8000_0003);
        tick();
        valid5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ack = 1'b1;
            #1;
            check("lb_busy_ready5",  ready5,   0);
            check("lb_busy_mem_req", mem_req,  1);
            check("lb_busy_mem_wen", mem_wen,  0);
            check("lb_busy_addr",    mem_addr, 64'h8000_0000);
            check("lb_busy_valid6",  valid6,   0);
            tick();
        end
        mem_ack = 1'b0;
        check("lb_valid6",      valid6,      1);
        check("lb_MEM_data1",   MEM_data1,   64'hFFFF_FFFF_FFFF_FF80);
        check("lb_ALU_result2", ALU_result2, 64'h8000_0003);
        check("lb_rdest3",      rdest3,      10);
        check("lb_WB_sel4",     WB_sel4,     1);
        check("lb_mem_req",     mem_req,     0);
        check("lb_ready5",      ready5,      1);
        tick();
        check("lb_valid6_drop", valid6, 0);

        // ---------------- lhu, ack in first BUSY cycle ----------------
        mem_rdata = 64'hBEEF_0000_0000_0000;
        drive_op(64'h8000_0014, mk_ins(3'b101, 7'h03), 0, 1, 1, 64'd0, 5'd11, 64'h8000_0006);
        tick();
        valid5  = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("lhu_mem_req", mem_req, 1);
        tick();
        mem_ack = 1'b0;
        check("lhu_valid6",    valid6,    1);
        check("lhu_MEM_data1", MEM_data1, 64'h0000_0000_0000_BEEF);
        tick();

        // ---------------- lw, sign extension ----------------
        mem_rdata = 64'h1234_5678_8765_4321;
        drive_op(64'h8000_0018, mk_ins(3'b010, 7'h03), 0, 1, 1, 64'd0, 5'd12, 64'h8000_0100);
        tick();
        valid5  = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("lw_MEM_data1", MEM_data1, 64'hFFFF_FFFF_8765_4321);
        tick();

        // ---------------- sw at offset 4 ----------------
        mem_rdata = 64'h5555_5555_5555_5555;
        drive_op(64'h8000_001C, mk_ins(3'b010, 7'h23), 1, 0, 0, 64'h0000_0000_DEAD_BEEF, 5'd0, 64'h8000_0004);
        tick();
        valid5 = 1'b0;
        check("sw_mem_req",   mem_req,   1);
        check("sw_mem_wen",   mem_wen,   1);
        check("sw_mem_wmask", mem_wmask, 8'hF0);
        check("sw_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0000);
        check("sw_mem_addr",  mem_addr,  64'h8000_0000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sw_valid6",    valid6,    1);
        check("sw_MEM_data1", MEM_data1, 0);
        tick();

        // ---------------- store+load flags together: sb at offset 1 ----------------
        drive_op(64'h8000_0020, mk_ins(3'b000, 7'h23), 1, 1, 0, 64'h0000_0000_0000_00AB, 5'd0, 64'h8000_0001);
        tick();
        valid5 = 1'b0;
        check("sb_mem_wen",   mem_wen,   1);
        check("sb_mem_wmask", mem_wmask, 8'h02);
        check("sb_mem_wdata", mem_wdata, 64'h0000_0000_0000_AB00);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sb_MEM_data1", MEM_data1, 0);
        tick();

        // ---------------- backpressure from WB ----------------
        ready6 = 1'b0;
        drive_op(64'h8000_0024, mk_ins(3'b000, 7'h33), 0, 0, 1, 64'd0, 5'd7, 64'h55);
        tick();
        drive_op(64'h8000_0028, mk_ins(3'b000, 7'h33), 0, 0, 1, 64'd0, 5'd8, 64'h66);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_valid6",      valid6,      1);
            check("bp_ALU_result2", ALU_result2, 64'h55);
            check("bp_rdest3",      rdest3,      7);
            check("bp_ready5",      ready5,      0);
            tick();
        end
        ready6 = 1'b1;
        #1;
        check("bp_ready5_release", ready5, 1);
        tick();
        valid5 = 1'b0;
        check("bp_next_valid6",      valid6,      1);
        check("bp_next_ALU_result2", ALU_result2, 64'h66);
        check("bp_next_rdest3",      rdest3,      8);
        tick();
        check("bp_valid6_drop", valid6, 0);

        // ---------------- reset during BUSY ----------------
        drive_op(64'h8000_002C, mk_ins(3'b011, 7'h03), 0, 1, 1, 64'd0, 5'd13, 64'h8000_0008);
        tick();
        valid5 = 1'b0;
        check("rb_mem_req_busy", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rb_mem_req_async", mem_req,  0);
        check("rb_valid6",        valid6,   0);
        check("rb_mem_addr",      mem_addr, 0);
        tick();
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rb_discarded_valid6", valid6,  0);
        check("rb_discarded_req",    mem_req, 0);

        // ---------------- lw at offset 2 ----------------
        mem_rdata = 64'hAABB_CCDD_1122_3344;
        drive_op(64'h8000_0030, mk_ins(3'b010, 7'h03), 0, 1, 1, 64'd0, 5'd14, 64'h8000_0002);
        tick();
        valid5 = 1'b0;
`ifdef YSYX_22041071_MEM_ALIGN_CHK_EN
        check("ma_mem_req",   mem_req,   0);
        check("ma_valid6",    valid6,    1);
        check("ma_misalign",  misalign,  1);
        check("ma_reg_w_en4", reg_w_en4, 0);
        check("ma_MEM_data1", MEM_data1, 0);
        tick();
        check("ma_mem_req_after", mem_req, 0);
`else
        check("ua_mem_req",  mem_req,  1);
        check("ua_misalign", misalign, 0);
        check("ua_mem_addr", mem_addr, 64'h8000_0000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ua_MEM_data1", MEM_data1, 64'hFFFF_FFFF_CCDD_1122);
        check("ua_misalign_done", misalign, 0);
        tick();

        // sd at offset 4: mask bits shifted past lane 7 are dropped
        drive_op(64'h8000_0034, mk_ins(3'b011, 7'h23), 1, 0, 0, 64'h0102_0304_0506_0708, 5'd0, 64'h8000_0004);
        tick();
        valid5 = 1'b0;
        check("sd_mem_wmask", mem_wmask, 8'hF0);
        check("sd_mem_wdata", mem_wdata, 64'h0506_0708_0000_0000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sd_valid6", valid6, 1);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
